// File: rtl/cic_pkg.sv
// Shared definitions for the multi-channel CIC decimator.
//   cic_width(n, rmax, m) : internal register width that absorbs the full
//                           CIC gain (rmax*m)^n without loss
//   N_MAX, M_MAX          : supported upper limits for order and differential delay
//   cic_acc_t             : accumulator type for the default N=3, RMAX=64, M=1 build
package cic_pkg;

  localparam int N_MAX = 6;
  localparam int M_MAX = 2;

  function automatic int cic_width(input int n, input int rmax, input int m);
    return n * $clog2(rmax * m) + 1;
  endfunction

  typedef logic [cic_width(3, 64, 1)-1:0] cic_acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC comb stage: out = in - in[z^-M], modulo 2^W.
// The delay line only advances on in_valid, so the comb operates at the
// decimated rate regardless of how sparse the ticks are.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   a new decimated sample is present on in
//   in         W-bit input sample
//   out_valid  in_valid delayed by one clock
//   out        W-bit comb result, updated one clock after in_valid
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = 19,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in,
  output logic         out_valid,
  output logic [W-1:0] out
);

  logic [W-1:0] dly [M];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      for (int i = 0; i < M; i++) dly[i] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        // Wrap-around subtraction is intended; the integrators overflow too.
        out    <= in - dly[M-1];
        dly[0] <= in;
        for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_decim_array.sv
// Multi-channel N-stage CIC decimator for 1-bit PDM streams. One packed PCM
// word (all channels) is produced per decimation period and handed over on a
// valid/ready output with sticky overrun detection.
// Optional build macro: CIC_ROUND_EN -- round-half-up with saturation to OUT_W
// bits, one extra clock of latency (N+2 instead of N+1).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   din          one PDM bit per channel (bit k = channel k)
//   din_valid    PDM sample strobe
//   dec_rate     decimation ratio minus one, takes effect at period boundaries
//   out          packed samples, channel k at [k*OUT_W +: OUT_W]
//   out_valid    out holds an unconsumed sample
//   out_ready    consumer accepts out when out_valid && out_ready
//   overrun      sticky: a sample was overwritten before acceptance
//   overrun_clr  synchronous clear of overrun (a coincident overrun wins)
module cic_decim_array
  import cic_pkg::*;
#(
  parameter int CH    = 2,
  parameter int N     = 3,
  parameter int M     = 1,
  parameter int RMAX  = 64,
  parameter int DEC_W = 16,
  parameter int OUT_W = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       din,
  input  logic                din_valid,
  input  logic [DEC_W-1:0]    dec_rate,
  output logic [CH*OUT_W-1:0] out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam int W = cic_width(N, RMAX, M);
  localparam int D = W - OUT_W;  // LSBs dropped at the output

  // ---------------------------------------------------------------------------
  // Shared decimation counter. Until the first post-reset clock has latched
  // dec_rate into r_cur, the live input is used so the first period is exact.
  // ---------------------------------------------------------------------------
  logic [DEC_W-1:0] cnt;
  logic [DEC_W-1:0] r_cur;
  logic [DEC_W-1:0] r_eff;
  logic             loaded;
  logic             tick;

  assign r_eff = loaded ? r_cur : dec_rate;
  assign tick  = din_valid && (cnt == r_eff);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      r_cur  <= '0;
      loaded <= 1'b0;
    end else begin
      loaded <= 1'b1;
      if (!loaded || tick) r_cur <= dec_rate;
      if (tick)           cnt <= '0;
      else if (din_valid) cnt <= cnt + DEC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Integrator chains: stage 0 adds din, stage i adds the previous stage.
  // ---------------------------------------------------------------------------
  logic [W-1:0] integ [CH][N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is a handful of registers, not a RAM, and a clean
      // start matters for the transient, so it is reset like any flop.
      for (int c = 0; c < CH; c++)
        for (int i = 0; i < N; i++) integ[c][i] <= '0;
    end else if (din_valid) begin
      for (int c = 0; c < CH; c++) begin
        integ[c][0] <= integ[c][0] + W'(din[c]);
        for (int i = 1; i < N; i++) integ[c][i] <= integ[c][i] + integ[c][i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comb pipelines, N stages per channel, fed with the last integrator on tick.
  // ---------------------------------------------------------------------------
  logic [CH-1:0]   comb_v;
  logic [CH*W-1:0] comb_d;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic         v [N+1];
    logic [W-1:0] d [N+1];

    assign v[0] = tick;
    assign d[0] = integ[c][N-1];

    for (genvar s = 0; s < N; s++) begin : g_stage
      cic_comb_stage #(.W(W), .M(M)) u_comb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v[s]),
        .in        (d[s]),
        .out_valid (v[s+1]),
        .out       (d[s+1])
      );
    end

    assign comb_v[c]          = v[N];
    assign comb_d[c*W +: W]   = d[N];
  end

  // ---------------------------------------------------------------------------
  // Width reduction to OUT_W. All channels tick together, so their valids
  // are identical; the AND just merges them into one strobe.
  // ---------------------------------------------------------------------------
  logic                new_v;
  logic [CH*OUT_W-1:0] new_d;

`ifdef CIC_ROUND_EN
  logic [CH*OUT_W-1:0] rnd;

  for (genvar c = 0; c < CH; c++) begin : g_rnd
    if (D > 0) begin : g_drop
      logic [OUT_W:0] sum;
      // Half-up: add the highest dropped bit; the carry out means saturation.
      assign sum = {1'b0, comb_d[c*W+D +: OUT_W]} + (OUT_W+1)'(comb_d[c*W+D-1]);
      assign rnd[c*OUT_W +: OUT_W] = sum[OUT_W] ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
    end else begin : g_keep
      assign rnd[c*OUT_W +: OUT_W] = comb_d[c*W +: OUT_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_v <= 1'b0;
      new_d <= '0;
    end else begin
      new_v <= &comb_v;
      if (&comb_v) new_d <= rnd;
    end
  end
`else
  for (genvar c = 0; c < CH; c++) begin : g_trunc
    assign new_d[c*OUT_W +: OUT_W] = comb_d[c*W+D +: OUT_W];
  end
  assign new_v = &comb_v;
`endif

  // ---------------------------------------------------------------------------
  // Output holding register with valid/ready and sticky overrun.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (new_v) begin
        out       <= new_d;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A new overrun event takes priority over a coincident clear.
      if (new_v && out_valid && !out_ready) overrun <= 1'b1;
      else if (overrun_clr)                 overrun <= 1'b0;
    end
  end

endmodule
